// File: rtl/types_pkg.sv
// types_pkg -- shared types for the instruction-memory loader.
// Provides the memory geometry (MEM_SIZE), the word address type, the
// instruction word type, the load-length type, and a helper that clamps
// a requested load length to the memory size.
package types_pkg;

  localparam int unsigned MEM_SIZE = 512;

  typedef logic [8:0]  address_t;
  typedef logic [31:0] word_t;
  typedef logic [9:0]  len_t;

  // Limit a requested word count to the number of words the memory holds.
  function automatic len_t clamp_len(input len_t n);
    if (n > len_t'(MEM_SIZE)) begin
      return len_t'(MEM_SIZE);
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- bundle of the loader's host-facing signals.
// Groups the load request, the byte stream handshake and the memory write
// port so an environment can carry them as one object.
//   master : the loader side (consumes start/bytes, drives memory port/status)
//   slave  : the host side (drives start/bytes, observes memory port/status)
interface imem_loader_if;
  import types_pkg::*;

  logic       start;
  len_t       word_count;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       mem_we;
  address_t   mem_addr;
  word_t      mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;

  modport master (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done
  );

  modport slave (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done
  );

endinterface

// File: rtl/imem_loader.sv
// imem_loader -- streams program bytes into the instruction memory.
// Bytes arriving on a valid/ready stream are packed four at a time into a
// 32-bit word (lane order selected by LITTLE_ENDIAN) and written to
// consecutive word addresses starting at 0. The core is held in reset for
// the whole load, and done pulses for one cycle when the load completes.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, word_count     load request and length (sampled only in IDLE)
//   byte_in, byte_valid   incoming byte stream
//   byte_ready            byte accepted this cycle (RECV only)
//   mem_we/addr/wdata     instruction memory write port
//   cpu_hold, busy, done  core hold, loader activity, completion pulse
module imem_loader
  import types_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  len_t       word_count,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       mem_we,
  output address_t   mem_addr,
  output word_t      mem_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state_r;
  logic [1:0] byte_cnt_r;
  address_t   addr_r;
  len_t       count_r;
  len_t       words_r;
  word_t      word_r;
  logic       byte_ready_r;
  logic       mem_we_r;
  logic       busy_r;
  logic       done_r;

  logic [1:0] lane_s;
  logic       accept_s;
  len_t       words_next_s;

  // Lane the next byte lands in: first byte is the LSB lane when little-endian.
  assign lane_s       = LITTLE_ENDIAN ? byte_cnt_r : (2'd3 - byte_cnt_r);
  // byte_ready_r is only ever set while in RECV, so this is a real transfer.
  assign accept_s     = byte_valid && byte_ready_r;
  assign words_next_s = words_r + 10'd1;

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      byte_cnt_r   <= 2'd0;
      addr_r       <= 9'd0;
      count_r      <= 10'd0;
      words_r      <= 10'd0;
      word_r       <= 32'd0;
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_we_r <= 1'b0;
          done_r   <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            if (word_count == 10'd0) begin
              done_r  <= 1'b1;
              state_r <= FINISH;
            end else begin
              count_r      <= clamp_len(word_count);
              addr_r       <= 9'd0;
              words_r      <= 10'd0;
              byte_cnt_r   <= 2'd0;
              byte_ready_r <= 1'b1;
              state_r      <= RECV;
            end
          end else begin
            busy_r       <= 1'b0;
            byte_ready_r <= 1'b0;
          end
        end

        RECV: begin
          if (accept_s) begin
            word_r[{lane_s, 3'b000} +: 8] <= byte_in;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              // Word complete: stop accepting and strobe the write next cycle.
              byte_ready_r <= 1'b0;
              mem_we_r     <= 1'b1;
              state_r      <= WRITE;
            end else begin
              state_r <= RECV;
            end
          end else begin
            state_r <= RECV;
          end
        end

        WRITE: begin
          mem_we_r <= 1'b0;
          words_r  <= words_next_s;
          if (words_next_s == count_r) begin
            // Address is left on the last word so a full 512-word load never wraps.
            done_r  <= 1'b1;
            state_r <= FINISH;
          end else begin
            addr_r       <= addr_r + 9'd1;
            byte_ready_r <= 1'b1;
            state_r      <= RECV;
          end
        end

        FINISH: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          state_r      <= IDLE;
          byte_ready_r <= 1'b0;
          mem_we_r     <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = word_r;
  assign busy       = busy_r;
  assign cpu_hold   = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- self-checking bench for imem_loader.
// Drives one little-endian and one big-endian loader from the same stimulus.
// Expected writes are derived from the byte stream itself (word k is bytes
// 4k..4k+3 packed in the chosen order, written to address k) and checked
// by a negedge monitor against what each loader puts on its memory port.
module tb_imem_loader;
  import types_pkg::*;

  typedef struct {
    address_t a;
    word_t    d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imem_loader_if lif ();
  imem_loader_if bif ();

  assign bif.start      = lif.start;
  assign bif.word_count = lif.word_count;
  assign bif.byte_in    = lif.byte_in;
  assign bif.byte_valid = lif.byte_valid;

  imem_loader #(.LITTLE_ENDIAN(1'b1)) u_le (
    .clk(clk), .rst(rst), .start(lif.start), .word_count(lif.word_count),
    .byte_in(lif.byte_in), .byte_valid(lif.byte_valid), .byte_ready(lif.byte_ready),
    .mem_we(lif.mem_we), .mem_addr(lif.mem_addr), .mem_wdata(lif.mem_wdata),
    .cpu_hold(lif.cpu_hold), .busy(lif.busy), .done(lif.done)
  );

  imem_loader #(.LITTLE_ENDIAN(1'b0)) u_be (
    .clk(clk), .rst(rst), .start(bif.start), .word_count(bif.word_count),
    .byte_in(bif.byte_in), .byte_valid(bif.byte_valid), .byte_ready(bif.byte_ready),
    .mem_we(bif.mem_we), .mem_addr(bif.mem_addr), .mem_wdata(bif.mem_wdata),
    .cpu_hold(bif.cpu_hold), .busy(bif.busy), .done(bif.done)
  );

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  wr_le = 0;
  int  wr_be = 0;
  int  last_we_cyc = -1;
  int  last_addr_le = 0;
  bit  check_rate = 1'b0;
  bit  prev_done = 1'b0;
  wr_t q_le[$];
  wr_t q_be[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter used for latency and throughput checks.
  always @(posedge clk) cyc++;

  // Monitor: every memory write must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (lif.mem_we === 1'b1) begin
      wr_le++;
      chk("le_ready_during_write", 32'(lif.byte_ready), 32'd0);
      if (q_le.size() == 0) begin
        tests++; fails++;
        $error("FAIL le_extra_write: observed addr 0x%0h expected no write", lif.mem_addr);
      end else begin
        e = q_le.pop_front();
        chk("le_addr", 32'(lif.mem_addr), 32'(e.a));
        chk("le_wdata", lif.mem_wdata, e.d);
      end
      if (check_rate && last_we_cyc >= 0) chk("throughput", 32'(cyc - last_we_cyc), 32'd5);
      last_we_cyc  = cyc;
      last_addr_le = int'(lif.mem_addr);
    end
    if (bif.mem_we === 1'b1) begin
      wr_be++;
      chk("be_ready_during_write", 32'(bif.byte_ready), 32'd0);
      if (q_be.size() == 0) begin
        tests++; fails++;
        $error("FAIL be_extra_write: observed addr 0x%0h expected no write", bif.mem_addr);
      end else begin
        e = q_be.pop_front();
        chk("be_addr", 32'(bif.mem_addr), 32'(e.a));
        chk("be_wdata", bif.mem_wdata, e.d);
      end
    end
    if (lif.done === 1'b1) chk("done_one_cycle", 32'(prev_done), 32'd0);
    prev_done = (lif.done === 1'b1);
    chk("hold_eq_busy", 32'(lif.cpu_hold), 32'(lif.busy));
  end

  // Expected writes for the first n words of a byte stream, addresses from 0.
  task automatic queue_words(input logic [7:0] b[$], input int n);
    for (int k = 0; k < n; k++) begin
      wr_t w;
      w.a = address_t'(k);
      w.d = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      q_le.push_back(w);
      w.d = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
      q_be.push_back(w);
    end
  endtask

  task automatic rand_bytes(output logic [7:0] b[$], input int n);
    b = {};
    for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic do_start(input int wc);
    lif.word_count = 10'(wc);
    lif.start      = 1'b1;
    @(negedge clk);
    lif.start      = 1'b0;
  endtask

  // Present each byte after an optional idle gap and hold it until accepted.
  task automatic send(input logic [7:0] b[$], input int max_gap, input bit poke_start);
    for (int i = 0; i < b.size(); i++) begin
      int w;
      lif.byte_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      lif.byte_valid = 1'b1;
      lif.byte_in    = b[i];
      w = 0;
      while (lif.byte_ready !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        tests++; fails++;
        $error("FAIL byte_accept_timeout: observed byte_ready 0 for 50 cycles expected 1");
        lif.byte_valid = 1'b0;
        lif.start      = 1'b0;
        return;
      end
      // Requests during a load must be ignored.
      lif.start = poke_start && (i < 4);
      if (poke_start) lif.word_count = 10'd7;
      @(negedge clk);
    end
    lif.byte_valid = 1'b0;
    lif.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int w;
    w = 0;
    while (lif.done !== 1'b1 && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_done_le"}, 32'(lif.done), 32'd1);
    chk({tag, "_done_be"}, 32'(bif.done), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(lif.byte_ready), 32'd0);
    chk({tag, "_we"},    32'(lif.mem_we),     32'd0);
    chk({tag, "_addr"},  32'(lif.mem_addr),   32'd0);
    chk({tag, "_wdata"}, lif.mem_wdata,       32'd0);
    chk({tag, "_busy"},  32'(lif.busy),       32'd0);
    chk({tag, "_hold"},  32'(lif.cpu_hold),   32'd0);
    chk({tag, "_done"},  32'(lif.done),       32'd0);
    chk({tag, "_be_we"}, 32'(bif.mem_we),     32'd0);
    chk({tag, "_be_busy"}, 32'(bif.busy),     32'd0);
  endtask

  initial begin
    logic [7:0] bq[$];
    int n;
    int wr0;

    rst = 1'b1;
    lif.start = 1'b0;
    lif.word_count = 10'd0;
    lif.byte_in = 8'd0;
    lif.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single word, back-to-back bytes, both byte orders.
    bq = '{8'h13, 8'h00, 8'h00, 8'h00};
    queue_words(bq, 1);
    do_start(1);
    chk("s1_busy_after_start", 32'(lif.busy), 32'd1);
    send(bq, 0, 1'b0);
    wait_done("s1", 20);
    chk("s1_done_latency", 32'(cyc - last_we_cyc), 32'd1);
    chk("s1_write_count", 32'(wr_le), 32'd1);
    @(negedge clk);
    chk("s1_idle_busy", 32'(lif.busy), 32'd0);
    chk("s1_idle_done", 32'(lif.done), 32'd0);

    // Zero-length load: done the cycle after start, no writes.
    wr0 = wr_le;
    do_start(0);
    chk("s0_done", 32'(lif.done), 32'd1);
    chk("s0_busy", 32'(lif.busy), 32'd1);
    @(negedge clk);
    chk("s0_done_cleared", 32'(lif.done), 32'd0);
    chk("s0_busy_cleared", 32'(lif.busy), 32'd0);
    chk("s0_no_writes", 32'(wr_le - wr0), 32'd0);

    // Three words with random gaps.
    wr0 = wr_le;
    rand_bytes(bq, 12);
    queue_words(bq, 3);
    do_start(3);
    send(bq, 3, 1'b0);
    wait_done("s3", 40);
    chk("s3_write_count", 32'(wr_le - wr0), 32'd3);
    @(negedge clk);

    // Random short loads with start pulses during the load.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(5, 2);
      wr0 = wr_le;
      rand_bytes(bq, 4 * n);
      queue_words(bq, n);
      do_start(n);
      send(bq, 2, 1'b1);
      wait_done("srand", 40);
      chk("srand_write_count", 32'(wr_le - wr0), 32'(n));
      @(negedge clk);
    end

    // Oversized request: clamped to 512 words, no gaps, full rate.
    wr0 = wr_le;
    rand_bytes(bq, 4 * 512);
    queue_words(bq, 512);
    check_rate  = 1'b1;
    last_we_cyc = -1;
    do_start(600);
    send(bq, 0, 1'b0);
    wait_done("s600", 20);
    check_rate = 1'b0;
    chk("s600_write_count", 32'(wr_le - wr0), 32'd512);
    chk("s600_last_addr", 32'(last_addr_le), 32'd511);
    @(negedge clk);
    chk("s600_idle", 32'(lif.busy), 32'd0);

    // Reset after 6 bytes of a 4-word load: only word 0 is written.
    wr0 = wr_le;
    rand_bytes(bq, 16);
    queue_words(bq, 1);
    do_start(4);
    send(bq[0:5], 0, 1'b0);
    chk("abort_busy_before", 32'(lif.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    chk("abort_write_count", 32'(wr_le - wr0), 32'd1);
    chk("abort_le_pending", 32'(q_le.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_late_write", 32'(wr_le - wr0), 32'd1);

    // Reload after the abort restarts from address 0.
    rand_bytes(bq, 8);
    queue_words(bq, 2);
    do_start(2);
    send(bq, 1, 1'b0);
    wait_done("reload", 30);
    @(negedge clk);

    chk("final_le_pending", 32'(q_le.size()), 32'd0);
    chk("final_be_pending", 32'(q_be.size()), 32'd0);
    chk("final_write_balance", 32'(wr_le), 32'(wr_be));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
